// File: rtl/picorv32_mem_arbiter_if.sv
// picorv32 native memory bus widened to N requesters: per-requester valid/instr/ready,
// packed addr/wdata/wstrb, and one shared rdata return path.
interface picorv32_mem_arbiter_if #(
    parameter int N = 1
);
    logic [N-1:0]    valid;
    logic [N-1:0]    instr;
    logic [32*N-1:0] addr;
    logic [32*N-1:0] wdata;
    logic [4*N-1:0]  wstrb;
    logic [N-1:0]    ready;
    logic [31:0]     rdata;

    modport master (
        output valid, instr, addr, wdata, wstrb,
        input  ready, rdata
    );

    modport slave (
        input  valid, instr, addr, wdata, wstrb,
        output ready, rdata
    );
endinterface

// File: rtl/picorv32_mem_arbiter.sv
// Two-master arbiter for one picorv32 native memory port: one registered transfer in
// flight, round-robin or fixed priority, and a watchdog that force-completes stalled slaves.
module picorv32_mem_arbiter #(
    parameter int unsigned PRIORITY_MODE = 0,
    parameter int unsigned TIMEOUT       = 1024,
    parameter logic [31:0] TIMEOUT_RDATA = 32'hdead_beef
) (
    input  logic                   clk,
    input  logic                   reset,
    picorv32_mem_arbiter_if.slave  m_mem,
    picorv32_mem_arbiter_if.master s_mem,
    output logic                   err_timeout,
    output logic                   err_master
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam bit          FIXED_PRIO    = (PRIORITY_MODE != 0);
    localparam bit          WATCHDOG_EN   = (TIMEOUT != 0);
    localparam logic [15:0] WATCHDOG_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

    logic [1:0]  state;
    logic        grant;
    logic        last_grant;
    logic [15:0] watchdog;
    logic        next_grant;
    logic [1:0]  grant_onehot;
    logic        timeout_hit;

    // A lone requester always wins; a tie goes to the master not served last, or to m0.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        next_grant = 1'b0;
        case (m_mem.valid)
            2'b10:   next_grant = 1'b1;
            2'b11:   next_grant = FIXED_PRIO ? 1'b0 : ~last_grant;
            default: next_grant = 1'b0;
        endcase
    end

    assign grant_onehot = grant ? 2'b10 : 2'b01;
    assign timeout_hit  = WATCHDOG_EN && (watchdog == WATCHDOG_LAST);

    // NOTE: all state here uses <= so each register samples the pre-edge value of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= 1'b0;
            last_grant  <= 1'b1;
            watchdog    <= 16'd0;
            s_mem.valid <= 1'b0;
            s_mem.instr <= 1'b0;
            s_mem.addr  <= 32'd0;
            s_mem.wdata <= 32'd0;
            s_mem.wstrb <= 4'd0;
            m_mem.ready <= 2'b00;
            m_mem.rdata <= 32'd0;
            err_timeout <= 1'b0;
            err_master  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|m_mem.valid) begin
                        grant       <= next_grant;
                        s_mem.valid <= 1'b1;
                        s_mem.instr <= m_mem.instr[next_grant];
                        s_mem.addr  <= m_mem.addr[{next_grant, 5'd0} +: 32];
                        s_mem.wdata <= m_mem.wdata[{next_grant, 5'd0} +: 32];
                        s_mem.wstrb <= m_mem.wstrb[{next_grant, 2'd0} +: 4];
                        state       <= BUSY;
                    end
                end

                BUSY: begin
                    // Saturate so a disabled watchdog never wraps back into range.
                    if (watchdog != 16'hffff) begin
                        watchdog <= watchdog + 16'd1;
                    end
                    if (s_mem.ready) begin
                        s_mem.valid <= 1'b0;
                        m_mem.rdata <= s_mem.rdata;
                        m_mem.ready <= grant_onehot;
                        last_grant  <= grant;
                        state       <= RESP;
                    end else if (timeout_hit) begin
                        s_mem.valid <= 1'b0;
                        m_mem.rdata <= TIMEOUT_RDATA;
                        m_mem.ready <= grant_onehot;
                        err_timeout <= 1'b1;
                        err_master  <= grant;
                        last_grant  <= grant;
                        state       <= RESP;
                    end
                end

                RESP: begin
                    // Requests are ignored here: the served master drops valid on this edge.
                    m_mem.ready <= 2'b00;
                    watchdog    <= 16'd0;
                    state       <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// Scoreboard bench: dut index 0 is round-robin, index 1 fixed priority, both TIMEOUT = 8.
module tb_picorv32_mem_arbiter;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        instr;
    } req_t;

    typedef struct {
        logic [1:0]  ready;
        logic [31:0] rdata;
        req_t        req;
        int          gap;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [1:0]  m_valid [2];
    logic [1:0]  m_instr [2];
    logic [63:0] m_addr  [2];
    logic [63:0] m_wdata [2];
    logic [7:0]  m_wstrb [2];
    logic [1:0]  m_ready [2];
    logic [31:0] m_rdata [2];
    logic        s_valid [2];
    logic        s_instr [2];
    logic [31:0] s_addr  [2];
    logic [31:0] s_wdata [2];
    logic [3:0]  s_wstrb [2];
    logic        s_ready [2];
    logic [31:0] s_rdata [2];
    logic        err_to  [2];
    logic        err_m   [2];

    for (genvar k = 0; k < 2; k++) begin : g_dut
        picorv32_mem_arbiter_if #(.N(2)) m_if ();
        picorv32_mem_arbiter_if #(.N(1)) s_if ();

        assign m_if.valid = m_valid[k];
        assign m_if.instr = m_instr[k];
        assign m_if.addr  = m_addr[k];
        assign m_if.wdata = m_wdata[k];
        assign m_if.wstrb = m_wstrb[k];
        assign m_ready[k] = m_if.ready;
        assign m_rdata[k] = m_if.rdata;
        assign s_valid[k] = s_if.valid;
        assign s_instr[k] = s_if.instr;
        assign s_addr[k]  = s_if.addr;
        assign s_wdata[k] = s_if.wdata;
        assign s_wstrb[k] = s_if.wstrb;
        assign s_if.ready = s_ready[k];
        assign s_if.rdata = s_rdata[k];

        picorv32_mem_arbiter #(
            .PRIORITY_MODE(k),
            .TIMEOUT(8),
            .TIMEOUT_RDATA(32'hdead_beef)
        ) dut (
            .clk(clk),
            .reset(reset),
            .m_mem(m_if),
            .s_mem(s_if),
            .err_timeout(err_to[k]),
            .err_master(err_m[k])
        );
    end

    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    req_t        mq [4][$];
    exp_t        expq [2][$];
    int          lat [2];
    logic [31:0] rd_base [2];
    int          scnt [2];
    int          vrun [2];
    int          vlen [2];
    int          last_rdy [2];
    logic        s_valid_q [2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic send(input int k, input int i, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wstrb, input logic instr,
                        input logic [31:0] rdata, input int gap);
        req_t r;
        exp_t e;
        r.addr  = addr;
        r.wdata = wdata;
        r.wstrb = wstrb;
        r.instr = instr;
        mq[2*k+i].push_back(r);
        e.ready = (i == 1) ? 2'b10 : 2'b01;
        e.rdata = rdata;
        e.req   = r;
        e.gap   = gap;
        expq[k].push_back(e);
    endtask

    // One cycle: monitor both DUTs at the falling edge, then update slave and master models.
    task automatic tick();
        @(negedge clk);
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (s_valid[k] && !s_valid_q[k]) begin
                if (expq[k].size() == 0) begin
                    check("req_expected", 64'(expq[k].size()), 64'd1);
                end else begin
                    check("s_addr",  s_addr[k],  expq[k][0].req.addr);
                    check("s_wdata", s_wdata[k], expq[k][0].req.wdata);
                    check("s_wstrb", s_wstrb[k], expq[k][0].req.wstrb);
                    check("s_instr", s_instr[k], expq[k][0].req.instr);
                end
            end
            if (s_valid[k]) begin
                vrun[k]++;
            end else if (s_valid_q[k]) begin
                vlen[k] = vrun[k];
                vrun[k] = 0;
            end
            s_valid_q[k] = s_valid[k];

            if (m_ready[k] != 2'b00) begin
                if (expq[k].size() == 0) begin
                    check("ready_expected", 64'(expq[k].size()), 64'd1);
                end else begin
                    exp_t e;
                    e = expq[k].pop_front();
                    check("m_ready", m_ready[k], e.ready);
                    check("m_rdata", m_rdata[k], e.rdata);
                    if (e.gap != 0) check("ready_gap", 64'(cyc - last_rdy[k]), 64'(e.gap));
                end
                last_rdy[k] = cyc;
            end

            if (s_ready[k]) begin
                s_ready[k] = 1'b0;
                scnt[k] = 0;
            end else if (s_valid[k]) begin
                scnt[k]++;
                if (lat[k] != 0 && scnt[k] == lat[k]) begin
                    s_ready[k] = 1'b1;
                    s_rdata[k] = rd_base[k] ^ s_addr[k];
                end
            end else begin
                scnt[k] = 0;
            end

            for (int i = 0; i < 2; i++) begin
                int q = 2*k + i;
                if (m_valid[k][i] && m_ready[k][i]) begin
                    mq[q].delete(0);
                    m_valid[k][i] = 1'b0;
                end
                if (!m_valid[k][i] && mq[q].size() != 0) begin
                    m_valid[k][i]         = 1'b1;
                    m_instr[k][i]         = mq[q][0].instr;
                    m_addr[k][i*32 +: 32] = mq[q][0].addr;
                    m_wdata[k][i*32 +: 32] = mq[q][0].wdata;
                    m_wstrb[k][i*4 +: 4]  = mq[q][0].wstrb;
                end
            end
        end
    endtask

    task automatic drain(input int k);
        int budget = 200;
        while ((expq[k].size() != 0 || mq[2*k].size() != 0 || mq[2*k+1].size() != 0)
               && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) check("drain_budget", 64'(expq[k].size()), 64'd0);
        tick();
    endtask

    task automatic check_idle(input int k);
        check("idle_m_ready", m_ready[k], 2'b00);
        check("idle_m_rdata", m_rdata[k], 32'd0);
        check("idle_s_valid", s_valid[k], 1'b0);
        check("idle_s_instr", s_instr[k], 1'b0);
        check("idle_s_addr",  s_addr[k],  32'd0);
        check("idle_s_wdata", s_wdata[k], 32'd0);
        check("idle_s_wstrb", s_wstrb[k], 4'd0);
        check("idle_err_to",  err_to[k],  1'b0);
        check("idle_err_m",   err_m[k],   1'b0);
    endtask

    initial begin
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = '0;  m_instr[k] = '0;  m_addr[k] = '0;
            m_wdata[k] = '0;  m_wstrb[k] = '0;  s_ready[k] = 1'b0;
            s_rdata[k] = '0;  lat[k] = 0;       rd_base[k] = '0;
            scnt[k] = 0;      vrun[k] = 0;      vlen[k] = 0;
            last_rdy[k] = 0;  s_valid_q[k] = 1'b0;
        end
        repeat (2) tick();
        check_idle(0);
        check_idle(1);
        reset = 1'b0;

        // Single read, slave answers on the second BUSY cycle.
        lat[0] = 2;
        rd_base[0] = 32'h1234_5778;
        send(0, 0, 32'h0000_0100, 32'h0, 4'h0, 1'b0, 32'h1234_5678, 0);
        tick();
        tick();
        check("rd_svalid_latency", s_valid[0], 1'b1);
        drain(0);
        check("rd_valid_len", 64'(vlen[0]), 64'd2);

        // Write from m1 is forwarded unchanged; rdata passes through and then holds.
        lat[0] = 1;
        rd_base[0] = 32'h0f0f_0f0f;
        send(0, 1, 32'h1000_0000, 32'hcafe_f00d, 4'b0110, 1'b0, 32'h1f0f_0f0f, 0);
        drain(0);
        repeat (2) tick();
        check("rdata_hold", m_rdata[0], 32'h1f0f_0f0f);

        // Round-robin with both masters saturating: 0,1,0,1 every 3 cycles.
        rd_base[0] = 32'h5555_0000;
        send(0, 0, 32'h0000_2000, 32'h0, 4'h0, 1'b1, 32'h5555_2000, 0);
        send(0, 1, 32'h0000_3000, 32'h0, 4'h0, 1'b0, 32'h5555_3000, 3);
        send(0, 0, 32'h0000_2004, 32'h0, 4'h0, 1'b0, 32'h5555_2004, 3);
        send(0, 1, 32'h0000_3004, 32'h1, 4'hf, 1'b0, 32'h5555_3004, 3);
        drain(0);

        // Fixed priority: m0 wins four times, m1 waits until m0 goes quiet.
        lat[1] = 1;
        rd_base[1] = 32'h7777_0000;
        send(1, 0, 32'h0000_4000, 32'h0, 4'h0, 1'b0, 32'h7777_4000, 0);
        send(1, 0, 32'h0000_4004, 32'h0, 4'h0, 1'b0, 32'h7777_4004, 3);
        send(1, 0, 32'h0000_4008, 32'h0, 4'h0, 1'b0, 32'h7777_4008, 3);
        send(1, 0, 32'h0000_400c, 32'h0, 4'h0, 1'b0, 32'h7777_400c, 3);
        send(1, 1, 32'h0000_4800, 32'h0, 4'h0, 1'b0, 32'h7777_4800, 3);
        drain(1);

        // Slave ready on the last watchdog cycle wins over the timeout.
        lat[0] = 8;
        rd_base[0] = 32'h1111_1111;
        send(0, 1, 32'h0000_5000, 32'h0, 4'h0, 1'b0, 32'h1111_4111, 0);
        drain(0);
        check("edge_valid_len", 64'(vlen[0]), 64'd8);
        check("edge_err_to", err_to[0], 1'b0);
        check("edge_err_m", err_m[0], 1'b0);

        // Slave never answers: forced completion with the timeout pattern and sticky error.
        lat[0] = 0;
        send(0, 1, 32'h0000_6000, 32'h0, 4'h0, 1'b0, 32'hdead_beef, 0);
        drain(0);
        check("to_valid_len", 64'(vlen[0]), 64'd8);
        check("to_err_to", err_to[0], 1'b1);
        check("to_err_m", err_m[0], 1'b1);
        lat[0] = 1;
        rd_base[0] = 32'h0;
        send(0, 0, 32'h0000_7000, 32'h0, 4'h0, 1'b0, 32'h0000_7000, 0);
        drain(0);
        check("to_err_to_sticky", err_to[0], 1'b1);
        check("to_err_m_sticky", err_m[0], 1'b1);

        // Reset in the middle of BUSY drops the transfer; the held m1 request is re-granted.
        lat[0] = 0;
        rd_base[0] = 32'h2222_0000;
        send(0, 1, 32'h0000_8000, 32'h0, 4'h0, 1'b0, 32'h2222_8000, 0);
        repeat (4) tick();
        reset = 1'b1;
        tick();
        check_idle(0);
        check_idle(1);
        reset = 1'b0;
        lat[0] = 2;
        tick();
        check("rst_regrant", s_valid[0], 1'b1);
        drain(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit: simulation did not reach the summary");
        $fatal(1);
    end
endmodule
